// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and instruction-fetch sequencer.
// Issues one read per instruction, holds the fetched word for decode,
// and accepts branch redirects from the branch unit.
// Optional feature: define PC_WRAP_TRAP_EN to trap on PC wrap-around
// instead of silently wrapping to zero.
module pc_fetch_ctrl #(
    parameter int AW = 8,
    parameter int DW = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          MEM_REQ,
    output logic [AW-1:0] MEM_ADDR,
    input  logic          MEM_READY,
    input  logic [DW-1:0] MEM_RDATA,
    output logic [DW-1:0] INST,
    output logic          INST_VALID,
    input  logic          INST_ACK,
    input  logic          BR_EN,
    input  logic [AW-1:0] BR_ADDR,
    output logic [AW-1:0] PC,
    output logic          TRAP
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
`ifdef PC_WRAP_TRAP_EN
        ,
        TRAPPED
`endif
    } state_t;

    state_t        state;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] inst_q;
    logic          req_q;
    logic          valid_q;
    logic          trap_q;

    // Single sequencer: state, PC, held word and all registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH: begin
                    if (BR_EN) begin
                        pc_q    <= BR_ADDR;
                        state   <= FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end else if (MEM_READY) begin
                        inst_q  <= MEM_RDATA;
                        state   <= HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (BR_EN) begin
                        pc_q    <= BR_ADDR;
                        state   <= FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end else if (INST_ACK) begin
`ifdef PC_WRAP_TRAP_EN
                        if (pc_q == {AW{1'b1}}) begin
                            state   <= TRAPPED;
                            req_q   <= 1'b0;
                            valid_q <= 1'b0;
                            trap_q  <= 1'b1;
                        end else begin
                            pc_q    <= pc_q + AW'(1);
                            state   <= FETCH;
                            req_q   <= 1'b1;
                            valid_q <= 1'b0;
                        end
`else
                        pc_q    <= pc_q + AW'(1);
                        state   <= FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
`endif
                    end
                end
`ifdef PC_WRAP_TRAP_EN
                TRAPPED: begin
                    state   <= TRAPPED;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    trap_q  <= 1'b1;
                end
`endif
                default: begin
                    state   <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    trap_q  <= 1'b0;
                end
            endcase
        end
    end

    assign PC         = pc_q;
    assign MEM_ADDR   = pc_q;
    assign MEM_REQ    = req_q;
    assign INST       = inst_q;
    assign INST_VALID = valid_q;
    assign TRAP       = trap_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed, table-driven bench for pc_fetch_ctrl.
// Define PC_WRAP_TRAP_EN for both files to exercise the trap build.
module tb_pc_fetch_ctrl;

    logic        CLK;
    logic        RST;
    logic        MEM_REQ;
    logic [7:0]  MEM_ADDR;
    logic        MEM_READY;
    logic [15:0] MEM_RDATA;
    logic [15:0] INST;
    logic        INST_VALID;
    logic        INST_ACK;
    logic        BR_EN;
    logic [7:0]  BR_ADDR;
    logic [7:0]  PC;
    logic        TRAP;

    int errors = 0;
    int checks = 0;

    pc_fetch_ctrl #(.AW(8), .DW(16), .RESET_PC(8'h00)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .MEM_REQ    (MEM_REQ),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_READY  (MEM_READY),
        .MEM_RDATA  (MEM_RDATA),
        .INST       (INST),
        .INST_VALID (INST_VALID),
        .INST_ACK   (INST_ACK),
        .BR_EN      (BR_EN),
        .BR_ADDR    (BR_ADDR),
        .PC         (PC),
        .TRAP       (TRAP)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        rst;
        logic        ready;
        logic [15:0] rdata;
        logic        ack;
        logic        br_en;
        logic [7:0]  br_addr;
        logic        exp_req;
        logic [7:0]  exp_pc;
        logic [15:0] exp_inst;
        logic        exp_valid;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    // Drive one cycle of inputs, clock it in, then settle past the edge.
    task automatic applyStimulus(input logic rst, input logic ready, input logic [15:0] rdata,
                                 input logic ack, input logic br_en, input logic [7:0] br_addr);
        RST       = rst;
        MEM_READY = ready;
        MEM_RDATA = rdata;
        INST_ACK  = ack;
        BR_EN     = br_en;
        BR_ADDR   = br_addr;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOne(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Compare every observable output against the expected values.
    task automatic checkOutput(input string tag, input logic exp_req, input logic [7:0] exp_pc,
                               input logic [15:0] exp_inst, input logic exp_valid, input logic exp_trap);
        checkOne({tag, " MEM_REQ"},    {15'b0, MEM_REQ},    {15'b0, exp_req});
        checkOne({tag, " MEM_ADDR"},   {8'b0, MEM_ADDR},    {8'b0, exp_pc});
        checkOne({tag, " PC"},         {8'b0, PC},          {8'b0, exp_pc});
        checkOne({tag, " INST"},       INST,                exp_inst);
        checkOne({tag, " INST_VALID"}, {15'b0, INST_VALID}, {15'b0, exp_valid});
        checkOne({tag, " TRAP"},       {15'b0, TRAP},       {15'b0, exp_trap});
    endtask

    initial begin
        RST = 1'b1; MEM_READY = 1'b0; MEM_RDATA = '0; INST_ACK = 1'b0; BR_EN = 1'b0; BR_ADDR = '0;

        //            rst  rdy  rdata     ack  br   br_addr  req  pc     inst      valid
        // reset held two cycles, then IDLE -> FETCH
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 16'h0000, 1'b0};
        // fetch A5A5, ack in first HOLD cycle
        vecs[3]  = '{1'b0, 1'b1, 16'hA5A5, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'hA5A5, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 16'hA5A5, 1'b0};
        // memory not ready for three cycles
        vecs[5]  = '{1'b0, 1'b0, 16'hDEAD, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 16'hA5A5, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 16'hDEAD, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 16'hA5A5, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'hDEAD, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 16'hA5A5, 1'b0};
        // fetch 1111, decode stalls four cycles, then acks
        vecs[8]  = '{1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 16'h1111, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 16'h1111, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 16'h1111, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 16'h8888, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 16'h1111, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 16'h1111, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 16'h1111, 1'b0};
        // branch in FETCH with READY: returned word dropped
        vecs[14] = '{1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1, 8'h40, 1'b1, 8'h40, 16'h1111, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 8'h00, 1'b0, 8'h40, 16'h2222, 1'b1};
        // branch in HOLD with ACK: no increment
        vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h40, 1'b1, 8'h40, 16'h2222, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 8'h00, 1'b0, 8'h40, 16'h3333, 1'b1};
        // branch in HOLD without ACK
        vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h10, 1'b1, 8'h10, 16'h3333, 1'b0};
        // ACK while fetching has no effect
        vecs[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 16'h3333, 1'b0};
        // reset, then branch during IDLE is ignored
        vecs[20] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h55, 1'b1, 8'h00, 16'h0000, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 16'h4444, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h4444, 1'b1};
        vecs[23] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 16'h4444, 1'b0};

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].ready, vecs[i].rdata,
                          vecs[i].ack, vecs[i].br_en, vecs[i].br_addr);
            checkOutput($sformatf("row%0d", i), vecs[i].exp_req, vecs[i].exp_pc,
                        vecs[i].exp_inst, vecs[i].exp_valid, 1'b0);
        end

        // Wrap-around: branch to FF, fetch, ack.
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'hFF);
        checkOutput("wrap_br", 1'b1, 8'hFF, 16'h4444, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h7777, 1'b0, 1'b0, 8'h00);
        checkOutput("wrap_fetch", 1'b0, 8'hFF, 16'h7777, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);
`ifdef PC_WRAP_TRAP_EN
        checkOutput("wrap_trap", 1'b0, 8'hFF, 16'h7777, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h6666, 1'b1, 1'b1, 8'h20);
        checkOutput("trap_br_ignored", 1'b0, 8'hFF, 16'h7777, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
        checkOutput("trap_sticky", 1'b0, 8'hFF, 16'h7777, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
        checkOutput("trap_reset", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
        checkOutput("trap_restart", 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0);
`else
        checkOutput("wrap_zero", 1'b1, 8'h00, 16'h7777, 1'b0, 1'b0);
`endif

        // Reset mid-fetch with READY: returned word must not be captured.
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h33);
        checkOutput("mid_br", 1'b1, 8'h33, INST, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00);
        checkOutput("mid_reset", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00);
        checkOutput("mid_idle", 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
